// File: rtl/alu_issue_arb_pkg.sv
// Shared execute-stage types: ALU function codes, data widths, request and
// result records, and the default destination tag width.
package alu_issue_arb_pkg;

  typedef logic        bool;
  typedef logic [31:0] xlen_t;
  typedef logic signed [31:0] slen_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_fun_t;

  localparam int unsigned ALU_TAG_W = 5;
  localparam int unsigned ALU_SRC_W = 2;

  // Value produced for function codes the ALU does not implement
  localparam xlen_t ALU_UNDEF = 32'hdeadbeef;

  typedef struct packed {
    xlen_t [1:0]           ops;
    alu_fun_t              fun;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_req_t;

  typedef struct packed {
    xlen_t                 data;
    logic [ALU_TAG_W-1:0]  tag;
    logic [ALU_SRC_W-1:0]  src;
  } alu_res_t;

endpackage

// File: rtl/alu_issue_arb_if.sv
// Requester/result bundle between reservation-station slots, the ALU issue
// arbiter and the writeback consumer. master = requesters + consumer side,
// slave = arbiter side.
interface alu_issue_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = alu_issue_arb_pkg::ALU_TAG_W
);
  import alu_issue_arb_pkg::*;

  bool      [NUM_REQ-1:0]            req_valid;
  xlen_t    [NUM_REQ-1:0][1:0]       req_ops;
  alu_fun_t [NUM_REQ-1:0]            req_fun;
  logic     [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  bool      [NUM_REQ-1:0]            req_ready;

  bool                               res_valid;
  xlen_t                             res_data;
  logic [TAG_W-1:0]                  res_tag;
  logic [$clog2(NUM_REQ)-1:0]        res_src;
  bool                               res_ready;

  modport master (
    output req_valid, req_ops, req_fun, req_tag, res_ready,
    input  req_ready, res_valid, res_data, res_tag, res_src
  );

  modport slave (
    input  req_valid, req_ops, req_fun, req_tag, res_ready,
    output req_ready, res_valid, res_data, res_tag, res_src
  );

endinterface

// File: rtl/alu.sv
// Single-cycle integer ALU. Unimplemented function codes yield 32'hdeadbeef;
// the output reads zero when no operation is presented.
module alu
  import alu_issue_arb_pkg::*;
(
  input  bool         valid,
  input  alu_fun_t    fun,
  input  xlen_t [1:0] ops,
  output xlen_t       opd
);

  xlen_t r;

  // Combinational operation select
  always_comb begin
    r = ALU_UNDEF;
    case (fun)
      ALU_ADD:  r = ops[0] + ops[1];
      ALU_SUB:  r = ops[0] - ops[1];
      ALU_AND:  r = ops[0] & ops[1];
      ALU_OR:   r = ops[0] | ops[1];
      ALU_XOR:  r = ops[0] ^ ops[1];
      ALU_SLL:  r = ops[0] << ops[1][4:0];
      ALU_SRL:  r = ops[0] >> ops[1][4:0];
      ALU_SRA:  r = xlen_t'(slen_t'(ops[0]) >>> ops[1][4:0]);
      ALU_SLT:  r = {31'd0, slen_t'(ops[0]) < slen_t'(ops[1])};
      ALU_SLTU: r = {31'd0, ops[0] < ops[1]};
      default:  r = ALU_UNDEF;
    endcase
    opd = valid ? r : '0;
  end

endmodule

// File: rtl/alu_issue_arb_rr_pick.sv
// Rotating-priority picker: first valid index scanning ptr, ptr+1, ...
// modulo N. Returns a one-hot grant (zero if nothing valid) and its index.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  int unsigned   j;
  logic [IW-1:0] jj;

  // Scan from ptr with wrap, first valid wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(ptr) + k) % N;
      jj = IW'(j);
      if (!found && valid[jj]) begin
        grant[jj] = 1'b1;
        idx       = jj;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arb.sv
// ALU issue arbiter: grants one valid requester per cycle into the shared
// ALU and registers result, tag and source index for writeback.
// ALU_ISSUE_ARB_RR_EN defined: round-robin priority pointer.
// ALU_ISSUE_ARB_RR_EN undefined: fixed priority, lowest valid index wins.
module alu_issue_arb
  import alu_issue_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = ALU_TAG_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  alu_issue_arb_if.slave bus
);

  localparam int unsigned SW = $clog2(NUM_REQ);

  logic               can_issue;
  logic               fire;
  logic [NUM_REQ-1:0] grant;
  logic [SW-1:0]      win_idx;
  logic [SW-1:0]      ptr_q;
  xlen_t              alu_opd;

  // Reset also blocks grants so req_ready reads zero while it is held
  assign can_issue     = !reset && !flush && (!bus.res_valid || bus.res_ready);
  assign bus.req_ready = can_issue ? grant : '0;
  assign fire          = |bus.req_ready;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx)
  );

  alu u_alu (
    .valid (fire),
    .fun   (bus.req_fun[win_idx]),
    .ops   (bus.req_ops[win_idx]),
    .opd   (alu_opd)
  );

`ifdef ALU_ISSUE_ARB_RR_EN
  // Priority pointer moves just past the requester that transferred
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (fire) begin
      ptr_q <= (win_idx == SW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign ptr_q = '0;
`endif

  // One-entry result register; load on transfer, else drain or hold
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_tag   <= '0;
      bus.res_src   <= '0;
    end else if (fire) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= alu_opd;
      bus.res_tag   <= bus.req_tag[win_idx];
      bus.res_src   <= win_idx;
    end else if (flush || bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arb.sv
// Directed self-checking bench for alu_issue_arb (4 requesters, 5-bit tags).
module tb_alu_issue_arb;
  import alu_issue_arb_pkg::*;

`ifdef ALU_ISSUE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  alu_issue_arb_if #(.NUM_REQ(4), .TAG_W(5)) bus ();

  alu_issue_arb #(.NUM_REQ(4), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic clear_reqs();
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_ops[i][0] = '0;
      bus.req_ops[i][1] = '0;
      bus.req_fun[i]    = ALU_ADD;
      bus.req_tag[i]    = '0;
    end
  endtask

  task automatic set_req(input int i, input xlen_t a, input xlen_t b,
                         input alu_fun_t f, input logic [4:0] t);
    bus.req_valid[i]  = 1'b1;
    bus.req_ops[i][0] = a;
    bus.req_ops[i][1] = b;
    bus.req_fun[i]    = f;
    bus.req_tag[i]    = t;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_reqs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    set_req(0, 32'd1, 32'd1, ALU_ADD, 5'd1);
    bus.res_ready = 1'b1;
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
    else n_pass++;
    n_total++;
    if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid);
    else n_pass++;
    n_total++;
    if (bus.res_data !== 32'd0) $display("FAIL reset_res_data: got %h expected 0", bus.res_data);
    else n_pass++;
    n_total++;
    if (bus.res_tag !== 5'd0 || bus.res_src !== 2'd0)
      $display("FAIL reset_tag_src: got tag %0d src %0d expected 0 0", bus.res_tag, bus.res_src);
    else n_pass++;
    clear_reqs();
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clock);
    bus.res_ready = 1'b1;
    set_req(2, 32'd5, 32'd7, ALU_ADD, 5'd9);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd12)
      $display("FAIL single_result: got v=%b %h expected v=1 0000000c", bus.res_valid, bus.res_data);
    else n_pass++;
    n_total++;
    if (bus.res_tag !== 5'd9 || bus.res_src !== 2'd2)
      $display("FAIL single_tag_src: got tag %0d src %0d expected 9 2", bus.res_tag, bus.res_src);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (bus.res_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", bus.res_valid);
    else n_pass++;
  endtask

  task automatic test_all_valid();
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, xlen_t'(i), 32'd100, ALU_ADD, 5'(i + 10));
    for (int k = 0; k < 8; k++) begin
      int e;
      @(negedge clock);
      e = RR ? (k % 4) : 0;
      n_total++;
      if (bus.res_valid !== 1'b1 || bus.res_src !== 2'(e) || bus.res_data !== xlen_t'(e + 100) || bus.res_tag !== 5'(e + 10))
        $display("FAIL all_valid_%0d: got v=%b src %0d data %0d tag %0d expected v=1 src %0d data %0d tag %0d",
                 k, bus.res_valid, bus.res_src, bus.res_data, bus.res_tag, e, e + 100, e + 10);
      else n_pass++;
    end
    clear_reqs();
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    set_req(0, 32'd3, 32'd5, ALU_SUB, 5'd1);
    bus.res_ready = 1'b1;
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL bp_first_ready: got %b expected 0001", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hfffffffe)
      $display("FAIL bp_sub: got v=%b %h expected v=1 fffffffe", bus.res_valid, bus.res_data);
    else n_pass++;
    bus.res_ready = 1'b0;
    set_req(0, 32'd10, 32'd20, ALU_ADD, 5'd3);
    set_req(2, 32'hffff0000, 32'h0f0f0f0f, ALU_XOR, 5'd4);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL bp_block_ready: got %b expected 0000", bus.req_ready);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_total++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hfffffffe || bus.res_src !== 2'd0 || bus.req_ready !== 4'b0000)
        $display("FAIL bp_hold_%0d: got v=%b data %h src %0d ready %b expected v=1 fffffffe 0 0000",
                 c, bus.res_valid, bus.res_data, bus.res_src, bus.req_ready);
      else n_pass++;
    end
    bus.res_ready = 1'b1;
    #1;
    n_total++;
    if (bus.req_ready !== (RR ? 4'b0100 : 4'b0001))
      $display("FAIL bp_release_ready: got %b expected %b", bus.req_ready, RR ? 4'b0100 : 4'b0001);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (bus.res_data !== (RR ? 32'hf0f00f0f : 32'd30) || bus.res_src !== (RR ? 2'd2 : 2'd0))
      $display("FAIL bp_release_result: got %h src %0d expected %h src %0d",
               bus.res_data, bus.res_src, RR ? 32'hf0f00f0f : 32'd30, RR ? 2 : 0);
    else n_pass++;
  endtask

  task automatic test_drain_accept();
    clear_reqs();
    set_req(1, 32'h80000000, 32'd4, ALU_SRA, 5'd7);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL drain_accept_ready: got %b expected 0010", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hf8000000 || bus.res_src !== 2'd1 || bus.res_tag !== 5'd7)
      $display("FAIL drain_accept_result: got v=%b %h src %0d tag %0d expected v=1 f8000000 1 7",
               bus.res_valid, bus.res_data, bus.res_src, bus.res_tag);
    else n_pass++;
  endtask

  task automatic test_flush();
    set_req(0, 32'd1, 32'd2, ALU_ADD, 5'd5);
    flush = 1'b1;
    bus.res_ready = 1'b0;
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0000) $display("FAIL flush_ready: got %b expected 0000", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    flush = 1'b0;
    n_total++;
    if (bus.res_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", bus.res_valid);
    else n_pass++;
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0001) $display("FAIL flush_regrant: got %b expected 0001", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd3 || bus.res_src !== 2'd0 || bus.res_tag !== 5'd5)
      $display("FAIL flush_result: got v=%b %h src %0d tag %0d expected v=1 00000003 0 5",
               bus.res_valid, bus.res_data, bus.res_src, bus.res_tag);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b1;
    set_req(2, 32'h000000f0, 32'h0000003c, ALU_AND, 5'd2);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0100) $display("FAIL rstmid_pre_ready: got %b expected 0100", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h30 || bus.res_src !== 2'd2)
      $display("FAIL rstmid_pre_result: got v=%b %h src %0d expected v=1 00000030 2",
               bus.res_valid, bus.res_data, bus.res_src);
    else n_pass++;
    bus.res_ready = 1'b0;
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    n_total++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 || bus.res_tag !== 5'd0 || bus.res_src !== 2'd0 || bus.req_ready !== 4'b0000)
      $display("FAIL rstmid_clear: got v=%b %h tag %0d src %0d ready %b expected all 0",
               bus.res_valid, bus.res_data, bus.res_tag, bus.res_src, bus.req_ready);
    else n_pass++;
    reset = 1'b0;
    flush = 1'b0;
    bus.res_ready = 1'b1;
    set_req(1, 32'd9, 32'd4, ALU_SUB, 5'd11);
    set_req(3, 32'd1, 32'd1, ALU_ADD, 5'd12);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b0010) $display("FAIL rstmid_first_grant: got %b expected 0010", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    bus.req_valid[1] = 1'b0;
    n_total++;
    if (bus.res_src !== 2'd1 || bus.res_data !== 32'd5 || bus.res_tag !== 5'd11)
      $display("FAIL rstmid_first_result: got src %0d %h tag %0d expected 1 00000005 11",
               bus.res_src, bus.res_data, bus.res_tag);
    else n_pass++;
    #1;
    n_total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL rstmid_second_grant: got %b expected 1000", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_src !== 2'd3 || bus.res_data !== 32'd2)
      $display("FAIL rstmid_second_result: got src %0d %h expected 3 00000002", bus.res_src, bus.res_data);
    else n_pass++;
  endtask

  task automatic test_undef_and_slt();
    set_req(3, 32'd1, 32'd2, alu_fun_t'(4'hf), 5'd31);
    #1;
    n_total++;
    if (bus.req_ready !== 4'b1000) $display("FAIL undef_ready: got %b expected 1000", bus.req_ready);
    else n_pass++;
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_data !== 32'hdeadbeef || bus.res_tag !== 5'd31 || bus.res_src !== 2'd3)
      $display("FAIL undef_result: got %h tag %0d src %0d expected deadbeef 31 3",
               bus.res_data, bus.res_tag, bus.res_src);
    else n_pass++;
    set_req(0, 32'hfffffffb, 32'd3, ALU_SLT, 5'd0);
    @(negedge clock);
    clear_reqs();
    n_total++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd1)
      $display("FAIL slt_result: got v=%b %h expected v=1 00000001", bus.res_valid, bus.res_data);
    else n_pass++;
    @(negedge clock);
  endtask

  initial begin
    bus.res_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_drain_accept();
    test_flush();
    test_reset_mid();
    test_undef_and_slt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
